// File: rtl/dcache_ctrl_if.sv
// Core-side and DRAM-side buses of the data cache controller.
// The cache is the slave of the core bus and the master of the DRAM bus.
interface dcache_cpu_if #(
    parameter int unsigned ADDR_LEN = 25
);
    logic                cpu_re;
    logic                cpu_we;
    logic [ADDR_LEN-1:0] cpu_addr;
    logic [31:0]         cpu_wdata;
    logic [31:0]         cpu_rdata;
    logic                stall;

    modport master (output cpu_re, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, stall);
    modport slave  (input cpu_re, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, stall);
endinterface

interface dcache_mem_if #(
    parameter int unsigned ADDR_LEN = 25
);
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_ready;
    logic                mem_rvalid;
    logic [31:0]         mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ready, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (one 32-bit word per line).
// Define DCACHE_PERF_CNT_EN to add saturating hit/miss/writeback counter outputs.
module dcache_ctrl #(
    parameter int unsigned ADDR_LEN  = 25,
    parameter int unsigned INDEX_LEN = 14
) (
    input  logic         clk,
    input  logic         rst,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt,
    output logic [31:0]  wb_cnt
`endif
);
    localparam int unsigned TAG_LEN = ADDR_LEN - INDEX_LEN;
    localparam int unsigned LINES   = 1 << INDEX_LEN;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WB, S_FILL, S_FWAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [INDEX_LEN-1:0] init_q, init_d;

    logic [31:0]          data_q  [LINES];
    logic [TAG_LEN-1:0]   tag_q   [LINES];
    logic                 valid_q [LINES];
    logic                 dirty_q [LINES];

    logic [INDEX_LEN-1:0] idx;
    logic [TAG_LEN-1:0]   tag;
    logic                 req, hit, victim_dirty;

    logic                 line_we, meta_we, wr_valid, wr_dirty;
    logic [INDEX_LEN-1:0] wr_idx;
    logic [TAG_LEN-1:0]   wr_tag;
    logic [31:0]          wr_data;
    logic                 rdata_we;
    logic [31:0]          rdata_d, rdata_q;
    logic                 stall_c;

    logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;

    assign idx          = cpu.cpu_addr[INDEX_LEN-1:0];
    assign tag          = cpu.cpu_addr[ADDR_LEN-1:INDEX_LEN];
    assign req          = cpu.cpu_re | cpu.cpu_we;
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];

    assign cpu.stall     = stall_c;
    assign cpu.cpu_rdata = rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_q      <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (rdata_we) rdata_q <= rdata_d;
        end
    end

    // Single write port for the line arrays; meta-only writes during the init sweep.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[wr_idx] <= wr_data;
            tag_q[wr_idx]  <= wr_tag;
        end
        if (meta_we) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        stall_c     = 1'b0;
        line_we     = 1'b0;
        meta_we     = 1'b0;
        wr_idx      = idx;
        wr_tag      = tag;
        wr_data     = cpu.cpu_wdata;
        wr_valid    = 1'b1;
        wr_dirty    = 1'b0;
        rdata_we    = 1'b0;
        rdata_d     = data_q[idx];
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_INIT: begin
                stall_c  = 1'b1;
                meta_we  = 1'b1;
                wr_idx   = init_q;
                wr_valid = 1'b0;
                // Counter saturates at the last index instead of wrapping.
                if (&init_q) state_d = S_IDLE;
                else         init_d  = init_q + INDEX_LEN'(1);
            end
            S_IDLE: begin
                if (req && hit) begin
                    if (cpu.cpu_we) begin
                        line_we  = 1'b1;
                        meta_we  = 1'b1;
                        wr_dirty = 1'b1;
                    end else begin
                        rdata_we = 1'b1;
                    end
                end else if (req) begin
                    stall_c = 1'b1;
                    if (victim_dirty) begin
                        state_d     = S_WB;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx};
                        mem_wdata_d = data_q[idx];
                    end else if (cpu.cpu_we) begin
                        state_d = S_RESP;
                    end else begin
                        state_d    = S_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu.cpu_addr;
                    end
                end
            end
            S_WB: begin
                stall_c = 1'b1;
                if (mem.mem_ready) begin
                    if (cpu.cpu_we) begin
                        state_d   = S_RESP;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d    = S_FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = cpu.cpu_addr;
                    end
                end
            end
            S_FILL: begin
                stall_c = 1'b1;
                if (mem.mem_ready) begin
                    state_d   = S_FWAIT;
                    mem_req_d = 1'b0;
                end
            end
            S_FWAIT: begin
                stall_c = 1'b1;
                if (mem.mem_rvalid) begin
                    state_d  = S_RESP;
                    line_we  = 1'b1;
                    meta_we  = 1'b1;
                    wr_data  = mem.mem_rdata;
                    rdata_we = 1'b1;
                    rdata_d  = mem.mem_rdata;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                // A store miss allocates the line directly; a load miss was filled in FWAIT.
                if (cpu.cpu_we) begin
                    line_we  = 1'b1;
                    meta_we  = 1'b1;
                    wr_dirty = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic hit_ev, miss_ev, wb_ev;

    assign hit_ev  = (state_q == S_IDLE) && req && hit;
    assign miss_ev = (state_q == S_IDLE) && req && !hit;
    assign wb_ev   = (state_q == S_WB) && mem.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_ev  && !(&hit_cnt))  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_ev && !(&miss_cnt)) miss_cnt <= miss_cnt + 32'd1;
            if (wb_ev   && !(&wb_cnt))   wb_cnt   <= wb_cnt + 32'd1;
        end
    end
`endif
endmodule
